// File: rtl/sram_arb_pkg.sv
// Shared types and default widths for the image-SRAM arbiter.
package sram_arb_pkg;

    localparam int ADDR_BITS_DEF     = 16;
    localparam int DATA_BITS_DEF     = 8;
    localparam int ACCESS_CYCLES_DEF = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } arb_state_t;

    typedef enum logic {
        BUS  = 1'b0,
        EDGE = 1'b1
    } req_id_t;

endpackage

// File: rtl/sram_rr_picker.sv
// Combinational 2-way round-robin choice between the bus loader and the edge core.
module sram_rr_picker
    import sram_arb_pkg::*;
(
    input  logic    bus_req_i,
    input  logic    edge_req_i,
    input  req_id_t last_grant_i,
    output logic    grant_valid_o,
    output req_id_t grant_id_o
);

    always_comb begin
        grant_valid_o = bus_req_i | edge_req_i;
        grant_id_o    = BUS;
        if (bus_req_i && edge_req_i) begin
            // Tie goes to whoever was not served last.
            grant_id_o = (last_grant_i == EDGE) ? BUS : EDGE;
        end else if (edge_req_i) begin
            grant_id_o = EDGE;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates the off-chip image SRAM between the AHB bus loader and the edge core,
// running each access with a fixed enable time and a one-cycle ack to the winner.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int ADDR_BITS     = ADDR_BITS_DEF,
    parameter int DATA_BITS     = DATA_BITS_DEF,
    parameter int ACCESS_CYCLES = ACCESS_CYCLES_DEF
) (
    input  logic                 AHB_HCLK,
    input  logic                 AHB_HRESET,
    input  logic                 bus_req,
    input  logic                 bus_write,
    input  logic [ADDR_BITS-1:0] bus_addr,
    input  logic [DATA_BITS-1:0] bus_wdata,
    output logic                 bus_ack,
    output logic [DATA_BITS-1:0] bus_rdata,
    input  logic                 edge_req,
    input  logic                 edge_write,
    input  logic [ADDR_BITS-1:0] edge_addr,
    input  logic [DATA_BITS-1:0] edge_wdata,
    output logic                 edge_ack,
    output logic [DATA_BITS-1:0] edge_rdata,
    output logic                 sram_read_enable,
    output logic                 sram_write_enable,
    output logic [ADDR_BITS-1:0] sram_address,
    output logic [DATA_BITS-1:0] sram_wdata,
    output logic                 sram_data_oe,
    input  logic [DATA_BITS-1:0] sram_rdata,
    output logic                 busy
);

    localparam int CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    arb_state_t           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    req_id_t              last_grant_q, last_grant_d;
    req_id_t              owner_q, owner_d;
    logic                 write_q, write_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [DATA_BITS-1:0] wdata_q, wdata_d;
    logic                 rd_en_q, rd_en_d;
    logic                 wr_en_q, wr_en_d;
    logic                 bus_ack_q, bus_ack_d;
    logic                 edge_ack_q, edge_ack_d;
    logic [DATA_BITS-1:0] bus_rdata_q, bus_rdata_d;
    logic [DATA_BITS-1:0] edge_rdata_q, edge_rdata_d;
    logic                 busy_q, busy_d;

    logic    grant_valid;
    req_id_t grant_id;

    sram_rr_picker u_picker (
        .bus_req_i     (bus_req),
        .edge_req_i    (edge_req),
        .last_grant_i  (last_grant_q),
        .grant_valid_o (grant_valid),
        .grant_id_o    (grant_id)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        owner_d      = owner_q;
        write_d      = write_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rd_en_d      = 1'b0;
        wr_en_d      = 1'b0;
        bus_ack_d    = 1'b0;
        edge_ack_d   = 1'b0;
        bus_rdata_d  = bus_rdata_q;
        edge_rdata_d = edge_rdata_q;

        case (state_q)
            IDLE: begin
                if (grant_valid) begin
                    state_d      = ACCESS;
                    cnt_d        = CNT_LOAD;
                    owner_d      = grant_id;
                    last_grant_d = grant_id;
                    // Only the winner's inputs are latched, so the loser never reaches the pins.
                    write_d      = (grant_id == BUS) ? bus_write : edge_write;
                    addr_d       = (grant_id == BUS) ? bus_addr  : edge_addr;
                    wdata_d      = (grant_id == BUS) ? bus_wdata : edge_wdata;
                    rd_en_d      = ~write_d;
                    wr_en_d      = write_d;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d = DONE;
                    if (owner_q == BUS) begin
                        bus_ack_d = 1'b1;
                        if (!write_q) bus_rdata_d = sram_rdata;
                    end else begin
                        edge_ack_d = 1'b1;
                        if (!write_q) edge_rdata_d = sram_rdata;
                    end
                end else begin
                    cnt_d   = cnt_q - CNT_ONE;
                    rd_en_d = ~write_q;
                    wr_en_d = write_q;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge AHB_HCLK) begin
        if (AHB_HRESET) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= EDGE;
            owner_q      <= BUS;
            write_q      <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rd_en_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            bus_ack_q    <= 1'b0;
            edge_ack_q   <= 1'b0;
            bus_rdata_q  <= '0;
            edge_rdata_q <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            owner_q      <= owner_d;
            write_q      <= write_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rd_en_q      <= rd_en_d;
            wr_en_q      <= wr_en_d;
            bus_ack_q    <= bus_ack_d;
            edge_ack_q   <= edge_ack_d;
            bus_rdata_q  <= bus_rdata_d;
            edge_rdata_q <= edge_rdata_d;
            busy_q       <= busy_d;
        end
    end

    assign sram_read_enable  = rd_en_q;
    assign sram_write_enable = wr_en_q;
    assign sram_data_oe      = wr_en_q;
    assign sram_address      = addr_q;
    assign sram_wdata        = wdata_q;
    assign bus_ack           = bus_ack_q;
    assign edge_ack          = edge_ack_q;
    assign bus_rdata         = bus_rdata_q;
    assign edge_rdata        = edge_rdata_q;
    assign busy              = busy_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: a 2-cycle build and a 1-cycle build, each on a byte SRAM model.
module tb_sram_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic srst;

    logic        bus_req, bus_write, edge_req, edge_write;
    logic [15:0] bus_addr, edge_addr;
    logic [7:0]  bus_wdata, edge_wdata;
    logic        bus_ack, edge_ack, rd_en, wr_en, data_oe, busy;
    logic [7:0]  bus_rdata, edge_rdata, sram_wdata, sram_rdata;
    logic [15:0] sram_address;

    logic        u1_bus_req, u1_bus_write, u1_edge_req, u1_edge_write;
    logic [15:0] u1_bus_addr, u1_edge_addr;
    logic [7:0]  u1_bus_wdata, u1_edge_wdata;
    logic        u1_bus_ack, u1_edge_ack, u1_rd_en, u1_wr_en, u1_data_oe, u1_busy;
    logic [7:0]  u1_bus_rdata, u1_edge_rdata, u1_sram_wdata, u1_sram_rdata;
    logic [15:0] u1_sram_address;

    logic [7:0] mem0 [0:65535];
    logic [7:0] mem1 [0:65535];

    int checks   = 0;
    int failures = 0;

    sram_arbiter #(.ADDR_BITS(16), .DATA_BITS(8), .ACCESS_CYCLES(2)) dut (
        .AHB_HCLK(clk), .AHB_HRESET(srst),
        .bus_req(bus_req), .bus_write(bus_write), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .edge_req(edge_req), .edge_write(edge_write), .edge_addr(edge_addr), .edge_wdata(edge_wdata),
        .edge_ack(edge_ack), .edge_rdata(edge_rdata),
        .sram_read_enable(rd_en), .sram_write_enable(wr_en), .sram_address(sram_address),
        .sram_wdata(sram_wdata), .sram_data_oe(data_oe), .sram_rdata(sram_rdata), .busy(busy)
    );

    sram_arbiter #(.ADDR_BITS(16), .DATA_BITS(8), .ACCESS_CYCLES(1)) dut1 (
        .AHB_HCLK(clk), .AHB_HRESET(srst),
        .bus_req(u1_bus_req), .bus_write(u1_bus_write), .bus_addr(u1_bus_addr), .bus_wdata(u1_bus_wdata),
        .bus_ack(u1_bus_ack), .bus_rdata(u1_bus_rdata),
        .edge_req(u1_edge_req), .edge_write(u1_edge_write), .edge_addr(u1_edge_addr), .edge_wdata(u1_edge_wdata),
        .edge_ack(u1_edge_ack), .edge_rdata(u1_edge_rdata),
        .sram_read_enable(u1_rd_en), .sram_write_enable(u1_wr_en), .sram_address(u1_sram_address),
        .sram_wdata(u1_sram_wdata), .sram_data_oe(u1_data_oe), .sram_rdata(u1_sram_rdata), .busy(u1_busy)
    );

    // Asynchronous-read SRAM models, written on the clock edge while the write strobe is high.
    assign sram_rdata    = mem0[sram_address];
    assign u1_sram_rdata = mem1[u1_sram_address];
    always @(posedge clk) begin
        if (wr_en)    mem0[sram_address]    <= sram_wdata;
        if (u1_wr_en) mem1[u1_sram_address] <= u1_sram_wdata;
    end

    // Strobe invariants, checked every cycle on both builds.
    always @(negedge clk) begin
        checks++;
        if ((rd_en && wr_en) || (data_oe !== wr_en) || (u1_rd_en && u1_wr_en) || (u1_data_oe !== u1_wr_en)) begin
            failures++;
            $display("FAIL strobe_invariant t=%0t got rd=%b wr=%b oe=%b u1rd=%b u1wr=%b u1oe=%b want rd&wr=0 oe=wr",
                     $time, rd_en, wr_en, data_oe, u1_rd_en, u1_wr_en, u1_data_oe);
        end
    end

    task automatic test_reset();
        srst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus_ack, edge_ack, rd_en, wr_en, data_oe, busy, sram_address, sram_wdata, bus_rdata, edge_rdata} !== 46'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h want=0",
                     {bus_ack, edge_ack, rd_en, wr_en, data_oe, busy, sram_address, sram_wdata, bus_rdata, edge_rdata});
        end
        checks++;
        if ({u1_bus_ack, u1_edge_ack, u1_rd_en, u1_wr_en, u1_busy, u1_sram_address} !== 21'd0) begin
            failures++;
            $display("FAIL reset_outputs_ac1 got=%h want=0",
                     {u1_bus_ack, u1_edge_ack, u1_rd_en, u1_wr_en, u1_busy, u1_sram_address});
        end
        srst = 1'b0;
    endtask

    task automatic test_bus_write();
        bus_req = 1'b1; bus_write = 1'b1; bus_addr = 16'h0010; bus_wdata = 8'hA5;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checks++;
            if (wr_en !== (k <= 2) || rd_en !== 1'b0) begin
                failures++;
                $display("FAIL bus_write_strobe k=%0d got wr=%b rd=%b want wr=%b rd=0", k, wr_en, rd_en, (k <= 2));
            end
            if (k <= 2) begin
                checks++;
                if (sram_address !== 16'h0010 || sram_wdata !== 8'hA5) begin
                    failures++;
                    $display("FAIL bus_write_pins k=%0d got addr=%h data=%h want addr=0010 data=a5", k, sram_address, sram_wdata);
                end
            end
            checks++;
            if (bus_ack !== (k == 3) || edge_ack !== 1'b0) begin
                failures++;
                $display("FAIL bus_write_ack k=%0d got bus=%b edge=%b want bus=%b edge=0", k, bus_ack, edge_ack, (k == 3));
            end
            checks++;
            if (busy !== (k <= 3)) begin
                failures++;
                $display("FAIL bus_write_busy k=%0d got=%b want=%b", k, busy, (k <= 3));
            end
            if (k == 3) begin bus_req = 1'b0; bus_write = 1'b0; end
        end
    endtask

    task automatic test_edge_read();
        edge_req = 1'b1; edge_write = 1'b0; edge_addr = 16'h0010;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks++;
            if (rd_en !== (k <= 2) || wr_en !== 1'b0) begin
                failures++;
                $display("FAIL edge_read_strobe k=%0d got rd=%b wr=%b want rd=%b wr=0", k, rd_en, wr_en, (k <= 2));
            end
            if (k <= 2) begin
                checks++;
                if (sram_address !== 16'h0010) begin
                    failures++;
                    $display("FAIL edge_read_addr k=%0d got=%h want=0010", k, sram_address);
                end
            end
            checks++;
            if (edge_ack !== (k == 3) || bus_ack !== 1'b0 || bus_rdata !== 8'h00) begin
                failures++;
                $display("FAIL edge_read_ack k=%0d got edge=%b bus=%b bus_rdata=%h want edge=%b bus=0 bus_rdata=00",
                         k, edge_ack, bus_ack, bus_rdata, (k == 3));
            end
            if (k == 3) begin
                checks++;
                if (edge_rdata !== 8'hA5) begin
                    failures++;
                    $display("FAIL edge_read_data got=%h want=a5", edge_rdata);
                end
                edge_req = 1'b0;
            end
        end
    endtask

    task automatic test_round_robin();
        bus_req  = 1'b1; bus_write  = 1'b1; bus_addr  = 16'h0100; bus_wdata  = 8'h11;
        edge_req = 1'b1; edge_write = 1'b1; edge_addr = 16'h0200; edge_wdata = 8'h22;
        for (int k = 1; k <= 16; k++) begin
            int   ph;
            logic own_bus;
            @(negedge clk);
            ph      = (k - 1) % 4;
            own_bus = (((k - 1) / 4) % 2) == 0;
            checks++;
            if (wr_en !== (ph < 2)) begin
                failures++;
                $display("FAIL rr_strobe k=%0d got=%b want=%b", k, wr_en, (ph < 2));
            end
            if (ph < 2) begin
                checks++;
                if (sram_address !== (own_bus ? 16'h0100 : 16'h0200) || sram_wdata !== (own_bus ? 8'h11 : 8'h22)) begin
                    failures++;
                    $display("FAIL rr_owner_pins k=%0d got addr=%h data=%h want addr=%h data=%h", k, sram_address,
                             sram_wdata, (own_bus ? 16'h0100 : 16'h0200), (own_bus ? 8'h11 : 8'h22));
                end
            end
            checks++;
            if (bus_ack !== (ph == 2 && own_bus) || edge_ack !== (ph == 2 && !own_bus)) begin
                failures++;
                $display("FAIL rr_ack k=%0d got bus=%b edge=%b want bus=%b edge=%b", k, bus_ack, edge_ack,
                         (ph == 2 && own_bus), (ph == 2 && !own_bus));
            end
            if (k == 15) begin bus_req = 1'b0; edge_req = 1'b0; bus_write = 1'b0; edge_write = 1'b0; end
        end
    endtask

    task automatic test_reset_mid_access();
        bus_req = 1'b1; bus_write = 1'b1; bus_addr = 16'h0300; bus_wdata = 8'h5A;
        @(negedge clk);
        checks++;
        if (wr_en !== 1'b1) begin
            failures++;
            $display("FAIL midrst_entry got wr=%b want 1", wr_en);
        end
        srst = 1'b1; bus_req = 1'b0; bus_write = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus_ack, edge_ack, rd_en, wr_en, data_oe, busy, sram_address, sram_wdata, bus_rdata, edge_rdata} !== 46'd0) begin
            failures++;
            $display("FAIL midrst_outputs got=%h want=0",
                     {bus_ack, edge_ack, rd_en, wr_en, data_oe, busy, sram_address, sram_wdata, bus_rdata, edge_rdata});
        end
        srst = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks++;
            if (bus_ack !== 1'b0 || wr_en !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL midrst_dropped k=%0d got ack=%b wr=%b busy=%b want 0 0 0", k, bus_ack, wr_en, busy);
            end
        end
        bus_req = 1'b1; bus_write = 1'b0; bus_addr = 16'h0010;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            checks++;
            if (rd_en !== (k <= 2) || bus_ack !== (k == 3)) begin
                failures++;
                $display("FAIL midrst_fresh k=%0d got rd=%b ack=%b want rd=%b ack=%b", k, rd_en, bus_ack, (k <= 2), (k == 3));
            end
            if (k == 3) begin
                checks++;
                if (bus_rdata !== 8'hA5) begin
                    failures++;
                    $display("FAIL midrst_fresh_data got=%h want=a5", bus_rdata);
                end
                bus_req = 1'b0;
            end
        end
    endtask

    task automatic test_single_cycle_access();
        u1_bus_req = 1'b1; u1_bus_write = 1'b0; u1_bus_addr = 16'h0000;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            checks++;
            if (u1_rd_en !== (k == 1 || k == 4) || u1_bus_ack !== (k == 2 || k == 5)) begin
                failures++;
                $display("FAIL ac1_timing k=%0d got rd=%b ack=%b want rd=%b ack=%b", k, u1_rd_en, u1_bus_ack,
                         (k == 1 || k == 4), (k == 2 || k == 5));
            end
            if (k == 1 || k == 4) begin
                checks++;
                if (u1_sram_address !== ((k == 1) ? 16'h0000 : 16'hFFFF)) begin
                    failures++;
                    $display("FAIL ac1_addr k=%0d got=%h want=%h", k, u1_sram_address, ((k == 1) ? 16'h0000 : 16'hFFFF));
                end
            end
            if (k == 2 || k == 5) begin
                checks++;
                if (u1_bus_rdata !== ((k == 2) ? 8'h3C : 8'hC3)) begin
                    failures++;
                    $display("FAIL ac1_data k=%0d got=%h want=%h", k, u1_bus_rdata, ((k == 2) ? 8'h3C : 8'hC3));
                end
            end
            if (k == 2) u1_bus_addr = 16'hFFFF;
            if (k == 5) u1_bus_req = 1'b0;
        end
    endtask

    initial begin
        srst = 1'b1;
        bus_req = 1'b0; bus_write = 1'b0; bus_addr = '0; bus_wdata = '0;
        edge_req = 1'b0; edge_write = 1'b0; edge_addr = '0; edge_wdata = '0;
        u1_bus_req = 1'b0; u1_bus_write = 1'b0; u1_bus_addr = '0; u1_bus_wdata = '0;
        u1_edge_req = 1'b0; u1_edge_write = 1'b0; u1_edge_addr = '0; u1_edge_wdata = '0;
        for (int a = 0; a < 65536; a++) begin
            mem0[a] = 8'h00;
            mem1[a] = 8'h00;
        end
        mem1[16'h0000] = 8'h3C;
        mem1[16'hFFFF] = 8'hC3;

        test_reset();
        test_bus_write();
        test_edge_read();
        test_round_robin();
        test_reset_mid_access();
        test_single_cycle_access();

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
